watch_time_ctrl: RTL and testbench

// - Timekeeping controller for the digital watch: derives a 1 Hz enable from clk and sequences the

---
 rtl/watch_pkg.sv | 28 ++
 rtl/mod_counter.sv | 34 +++
 rtl/watch_time_ctrl.sv | 136 +++++++++++++
 tb/tb_watch_time_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared encodings and field constants for the watch timekeeping path.
// Mode values are also the encoding seen on the mode output.
package watch_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

    localparam int HR_MOD  = 24;
    localparam int MIN_MOD = 60;
    localparam int SEC_MOD = 60;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    // Mode sequence driven by btn_mode; the unused code falls back to RUN.
    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            MODE_RUN:     nxt = MODE_SET_HR;
            MODE_SET_HR:  nxt = MODE_SET_MIN;
            default:      nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear and a combinational wrap flag.
// wrap marks the enabled cycle on which the count returns to zero.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = en && (q == LAST);

    // clr wins over en so a mode change can restart a field cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (wrap) begin
                q <= '0;
            end else begin
                q <= q + W'(1);
            end
        end
    end

endmodule

// File: rtl/watch_time_ctrl.sv
// Watch timekeeping controller: 1 Hz prescaler, h:m:s counters and the RUN/SET_HR/SET_MIN
// mode sequencer, all on clk with single-cycle enables.
module watch_time_ctrl
    import watch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_mode,
    input  logic             btn_inc,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic [1:0]       mode,
    output logic             blink,
    output logic             sec_tick,
    output logic             day_pulse
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [1:0]       mode_q;
    logic             blink_q;
    logic             sec_tick_q;
    logic             day_pulse_q;

    logic [PRE_W-1:0] pre_q;
    logic             tick;
    logic             pre_clr;
    logic             unused_pre;

    logic             in_run;
    logic             in_set_hr;
    logic             in_set_min;
    logic             inc;

    logic             sec_en;
    logic             sec_clr;
    logic             sec_wrap;
    logic             min_en;
    logic             min_wrap;
    logic             hr_en;
    logic             hr_wrap;

    assign in_run     = (mode_q == MODE_RUN);
    assign in_set_hr  = (mode_q == MODE_SET_HR);
    assign in_set_min = (mode_q == MODE_SET_MIN);

    // btn_mode takes priority over every other event in the same cycle.
    assign inc     = btn_inc && !btn_mode;
    assign sec_en  = in_run && tick && !btn_mode;
    assign sec_clr = in_run && btn_mode;
    assign min_en  = in_run ? sec_wrap : (in_set_min && inc);
    assign hr_en   = in_run ? min_wrap : (in_set_hr && inc);

    // Leaving SET_MIN restarts the second so the first one after setting is full length.
    assign pre_clr = in_set_min && btn_mode;

    assign unused_pre = ^pre_q;

    mod_counter #(
        .MOD (TICK_DIV),
        .W   (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .en    (1'b1),
        .q     (pre_q),
        .wrap  (tick)
    );

    mod_counter #(
        .MOD (SEC_MOD),
        .W   (SEC_W)
    ) u_seconds (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sec_clr),
        .en    (sec_en),
        .q     (seconds),
        .wrap  (sec_wrap)
    );

    mod_counter #(
        .MOD (MIN_MOD),
        .W   (MIN_W)
    ) u_minutes (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (min_en),
        .q     (minutes),
        .wrap  (min_wrap)
    );

    mod_counter #(
        .MOD (HR_MOD),
        .W   (HR_W)
    ) u_hours (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (hr_en),
        .q     (hours),
        .wrap  (hr_wrap)
    );

    // Hours also wrap while being set; only a RUN carry counts as a new day.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_RUN;
            blink_q     <= 1'b0;
            sec_tick_q  <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            sec_tick_q  <= tick;
            day_pulse_q <= in_run && hr_wrap;
            if (btn_mode) begin
                mode_q  <= next_mode(mode_q);
                blink_q <= 1'b0;
            end else if (in_run) begin
                blink_q <= 1'b0;
            end else if (tick) begin
                blink_q <= ~blink_q;
            end
        end
    end

    assign mode      = mode_q;
    assign blink     = blink_q;
    assign sec_tick  = sec_tick_q;
    assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Directed bench for watch_time_ctrl with TICK_DIV=4: reset, ticking, set-mode wraps,
// button conflicts, exit timing, midnight rollover and asynchronous reset.
module tb_watch_time_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       sec_tick;
    logic       day_pulse;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    watch_time_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .mode      (mode),
        .blink     (blink),
        .sec_tick  (sec_tick),
        .day_pulse (day_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
    endtask

    task automatic hold_inc(input int n);
        btn_inc = 1'b1;
        repeat (n) @(negedge clk);
        btn_inc = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hours"}, int'(hours), h);
        check({tag, "_minutes"}, int'(minutes), m);
        check({tag, "_seconds"}, int'(seconds), s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dp_count;
        int hr_bad;
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;

        cyc(2);
        check_time("reset", 0, 0, 0);
        check("reset_mode", int'(mode), 0);
        check("reset_blink", int'(blink), 0);
        check("reset_sec_tick", int'(sec_tick), 0);
        check("reset_day_pulse", int'(day_pulse), 0);

        // Release; edge k counts posedges after release.
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("release_sec_tick", int'(sec_tick), (k % 4 == 0) ? 1 : 0);
            if (k == 3) check("release_sec_k3", int'(seconds), 0);
            if (k == 4) check("release_sec_k4", int'(seconds), 1);
        end
        check_time("release_k12", 0, 0, 3);
        check("release_mode", int'(mode), 0);
        check("release_blink", int'(blink), 0);

        // Run to 00:00:59, then press mode on the tick edge (k=240).
        cyc(224);
        check("run_sec_k236", int'(seconds), 59);
        cyc(3);
        check_time("run_k239", 0, 0, 59);
        press_mode();
        check("mode_tick_mode", int'(mode), 1);
        check_time("mode_tick", 0, 0, 0);
        check("mode_tick_day_pulse", int'(day_pulse), 0);
        check("mode_tick_sec_tick", int'(sec_tick), 1);
        check("mode_tick_blink", int'(blink), 0);

        // SET_HR: 25 increments, ticks on every 4th edge toggle blink.
        btn_inc = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            check("set_hr_hours", int'(hours), i % 24);
            check("set_hr_blink", int'(blink), (i / 4) % 2);
        end
        btn_inc = 1'b0;
        check_time("set_hr_end", 1, 0, 0);

        // btn_mode with btn_inc: mode advances, hours untouched, blink cleared.
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        check("conflict_mode", int'(mode), 2);
        check("conflict_hours", int'(hours), 1);
        check("conflict_blink", int'(blink), 0);

        // SET_MIN: 61 increments (edges 267..327), 15 ticks in between.
        hold_inc(61);
        check_time("set_min_end", 1, 1, 0);
        check("set_min_blink", int'(blink), 1);
        check("set_min_mode", int'(mode), 2);
        cyc(2);
        check("set_min_blink_after_tick", int'(blink), 0);

        // Exit on edge 330 with the prescaler at 1; next tick must be 4 edges later.
        press_mode();
        check("exit_mode", int'(mode), 0);
        check("exit_blink", int'(blink), 0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check("exit_sec_tick", int'(sec_tick), (j == 4) ? 1 : 0);
            check("exit_seconds", int'(seconds), (j == 4) ? 1 : 0);
        end

        // Set 23:59 and return to RUN.
        press_mode();
        check("to_set_hr_seconds", int'(seconds), 0);
        hold_inc(22);
        check("hours_23", int'(hours), 23);
        press_mode();
        hold_inc(58);
        check_time("preset", 23, 59, 0);
        press_mode();
        check("preset_mode", int'(mode), 0);

        dp_count = 0;
        hr_bad   = 0;
        for (int i = 1; i <= 244; i++) begin
            @(negedge clk);
            if (day_pulse) dp_count++;
            if (hours > 5'd23) hr_bad++;
            if (i == 236) check_time("roll_i236", 23, 59, 59);
            if (i == 239) begin
                check_time("roll_i239", 23, 59, 59);
                check("roll_i239_day_pulse", int'(day_pulse), 0);
            end
            if (i == 240) begin
                check_time("roll_i240", 0, 0, 0);
                check("roll_i240_day_pulse", int'(day_pulse), 1);
            end
            if (i == 241) check("roll_i241_day_pulse", int'(day_pulse), 0);
        end
        check("roll_day_pulse_count", dp_count, 1);
        check("roll_hours_over_23", hr_bad, 0);
        check_time("roll_i244", 0, 0, 1);

        // Set 12:34 and reset asynchronously between clock edges.
        press_mode();
        hold_inc(12);
        press_mode();
        hold_inc(34);
        check_time("preset_reset", 12, 34, 0);
        check("preset_reset_mode", int'(mode), 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_time("async_reset", 0, 0, 0);
        check("async_reset_mode", int'(mode), 0);
        check("async_reset_blink", int'(blink), 0);
        check("async_reset_sec_tick", int'(sec_tick), 0);
        check("async_reset_day_pulse", int'(day_pulse), 0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        check("rerelease_sec_tick_k3", int'(sec_tick), 0);
        cyc(1);
        check("rerelease_sec_tick_k4", int'(sec_tick), 1);
        check_time("rerelease_k4", 0, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
